// File: rtl/auth_pkg.sv
// auth_pkg: shared types and defaults for the authentication responder scheduler.
package auth_pkg;
   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, TOUT} sched_state_t;
   localparam int AUTH_MSG_W            = 1000;
   localparam int AUTH_RESP_TIMEOUT_DEF = 1000;
endpackage

// File: rtl/auth_rr_arb.sv
// auth_rr_arb: combinational round-robin pick, searching from last_grant+1 with wrap-around.
module auth_rr_arb #(
   parameter int N_REQ = 2,
   parameter int IW    = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [IW-1:0]    last_grant_i,
   output logic [N_REQ-1:0] gnt_o,
   output logic [IW-1:0]    idx_o
);
   logic found;
   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      found = 1'b0;
      for (int k = 1; k <= N_REQ; k++) begin
         if (!found && req_i[(int'(last_grant_i) + k) % N_REQ]) begin
            found = 1'b1;
            gnt_o[(int'(last_grant_i) + k) % N_REQ] = 1'b1;
            idx_o = IW'((int'(last_grant_i) + k) % N_REQ);
         end
      end
   end
endmodule

// File: rtl/auth_resp_sched.sv
// auth_resp_sched: shares one authentication responder between N_REQ requesters, round-robin,
// with a response timeout and a saturating count of replies that arrive outside WAIT.
module auth_resp_sched
   import auth_pkg::*;
#(
   parameter int N_REQ       = 2,
   parameter int MSG_W       = AUTH_MSG_W,
   parameter int TIMEOUT_CYC = AUTH_RESP_TIMEOUT_DEF
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [N_REQ-1:0]       rq_req,
   input  logic [N_REQ*MSG_W-1:0] rq_msg,
   output logic [N_REQ-1:0]       rq_grant,
   output logic [N_REQ-1:0]       rq_done,
   output logic [N_REQ-1:0]       rq_timeout,
   output logic [MSG_W-1:0]       rq_resp_msg,
   output logic                   rsp_req_o,
   output logic [MSG_W-1:0]       rsp_msg_o,
   input  logic                   rsp_ack_i,
   input  logic [MSG_W-1:0]       rsp_msg_i,
   output logic                   busy,
   output logic [7:0]             late_cnt
);
   localparam int IW = $clog2(N_REQ);
   localparam int CW = $clog2(TIMEOUT_CYC + 1);
   sched_state_t     state_q, state_d;
   logic [IW-1:0]    last_q, last_d, gidx_q, gidx_d, arb_idx;
   logic [N_REQ-1:0] grant_q, grant_d, arb_gnt;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [MSG_W-1:0] msg_q, msg_d, resp_q, resp_d;
   logic [7:0]       late_q, late_d;
   auth_rr_arb #(.N_REQ(N_REQ), .IW(IW)) u_arb (
      .req_i        (rq_req),
      .last_grant_i (last_q),
      .gnt_o        (arb_gnt),
      .idx_o        (arb_idx)
   );
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      gidx_d  = gidx_q;
      grant_d = grant_q;
      cnt_d   = cnt_q;
      msg_d   = msg_q;
      resp_d  = resp_q;
      late_d  = (rsp_ack_i && state_q != WAIT && late_q != 8'hFF) ? late_q + 8'd1 : late_q;
      case (state_q)
         IDLE: if (|rq_req) begin
            msg_d   = rq_msg[int'(arb_idx)*MSG_W +: MSG_W];
            grant_d = arb_gnt;
            gidx_d  = arb_idx;
            state_d = ISSUE;
         end
         ISSUE: begin
            cnt_d   = '0;
            state_d = WAIT;
         end
         // The final WAIT cycle is the one with cnt_q==TIMEOUT_CYC, giving TOUT TIMEOUT_CYC+2 after ISSUE.
         WAIT: begin
            cnt_d = cnt_q + CW'(1);
            if (rsp_ack_i) begin
               resp_d  = rsp_msg_i;
               state_d = DONE;
            end else if (cnt_q == CW'(TIMEOUT_CYC))
               state_d = TOUT;
         end
         DONE, TOUT: begin
            last_d  = gidx_q;
            grant_d = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         last_q  <= IW'(N_REQ - 1);
         gidx_q  <= '0;
         grant_q <= '0;
         cnt_q   <= '0;
         msg_q   <= '0;
         resp_q  <= '0;
         late_q  <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         gidx_q  <= gidx_d;
         grant_q <= grant_d;
         cnt_q   <= cnt_d;
         msg_q   <= msg_d;
         resp_q  <= resp_d;
         late_q  <= late_d;
      end
   end
   assign rq_grant    = grant_q;
   assign rq_done     = (state_q == DONE) ? grant_q : '0;
   assign rq_timeout  = (state_q == TOUT) ? grant_q : '0;
   assign rq_resp_msg = resp_q;
   assign rsp_req_o   = (state_q == ISSUE);
   assign rsp_msg_o   = msg_q;
   assign busy        = (state_q != IDLE);
   assign late_cnt    = late_q;
endmodule
